ps2_kbd_rx: RTL
===============

Name: ps2_kbd_rx

Overview:
Receives PS/2 keyboard frames, validates them and buffers the scan codes in a small FIFO. It sits directly upstream of the hex seven-segment decoders. A consumer pops codes with a valid/ready handshake and splits each byte into two nibbles, one per bcd7seg instance. Errors and FIFO overflow are reported through sticky flags.

Parameters:
FIFO_DEPTH, 8, number of scan-code entries; power of two, minimum 2
TIMEOUT_CYC, 10000, clk cycles without a ps2_clk falling edge before a partial frame is discarded

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
ps2_clk  input  1  raw PS/2 clock from the pad; asynchronous to clk
ps2_data  input  1  raw PS/2 data from the pad; asynchronous to clk
code_ready  input  1  consumer accepts code_data this cycle
code_valid  output  1  FIFO non-empty
code_data  output  8  oldest scan code in the FIFO (first-word fall-through)
frame_err  output  1  sticky: a frame had a bad start, stop or parity bit
overflow  output  1  sticky: a valid frame was dropped because the FIFO was full
clr_err  input  1  synchronous clear of frame_err and overflow

Behaviour:
- Reset: asynchronous on rst_n low.
  - Outputs: code_valid=0, code_data=8'h00, frame_err=0, overflow=0.
  - Internal state: FIFO empty, bit counter=0, timeout counter=0.
  - Synchronizers reset to 1 (PS/2 idle level).
- Input sync: ps2_clk and ps2_data each pass through a 2-flop synchronizer. A third flop holds the previous synced ps2_clk. A falling edge is detected when prev=1 and synced=0, giving a one-clk pulse.
- Frame capture: on each falling edge, sample synced ps2_data into a 10-bit shift register and increment the bit counter 0..10.
  - Bit order: start, d0..d7 (LSB first), parity, stop.
- Frame end (counter==10 on a falling edge):
  - Valid when: start==0, stop==1, and the XOR of d0..d7 and parity equals 1 (odd parity).
  - Valid and FIFO not full: push the byte.
  - Valid and FIFO full: drop the byte and set overflow.
  - Invalid: drop the byte and set frame_err.
  - In every case the bit counter returns to 0.
- Timeout: while bit counter!=0, count clk cycles since the last falling edge. When the count reaches TIMEOUT_CYC, clear the bit counter and discard the partial frame. No error flag is set. The timeout counter is held at 0 when the bit counter is 0.
- Latency: code_valid rises after the 3rd rising clk edge following the ps2_clk falling edge of the stop bit.
- FIFO:
  - code_valid = (count!=0); code_data = mem[rd_ptr].
  - Pop when code_valid && code_ready.
  - Push and pop in the same cycle: both take effect and count is unchanged. This also applies when full, where the push is accepted and overflow is not set.
  - Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
  - code_data is don't-care while code_valid=0, but must not be X after reset.
- Sticky flags: clr_err clears both flags. If a new error event occurs in the same cycle as clr_err, the flag is set, because set takes priority.
- Reset mid-frame: the partial frame is lost, and the next full frame after reset is received normally.
- Idle line, or a frame never reaching 11 edges: no output activity apart from the timeout.

Decomposition:
- Package ps2_pkg:
  - Constants PS2_FRAME_BITS=11, PS2_BREAK=8'hF0, PS2_EXT=8'hE0.
  - Typedef scan_code_t = logic [7:0].
- Sub-module ps2_fifo: synchronous FWFT FIFO with parameter DEPTH and ports clk, rst_n, push, push_data, pop, full, empty, rd_data.
- Frame FSM/shift logic, synchronizers, timeout and flags stay in ps2_kbd_rx.

Test Plan:
- Valid frame, scan code 8'h1C (bits 0,0,0,1,1,1,0,0,0 LSB-first, parity=0, stop=1), code_ready=0 -> code_valid=1, code_data=8'h1C 3 clk after the stop edge; frame_err=0.
- Frame 8'h1C sent with parity=1 -> nothing pushed, code_valid stays 0, frame_err=1. Then pulse clr_err -> frame_err=0.
- 9 valid frames 8'h01..8'h09 with code_ready=0 (FIFO_DEPTH=8) -> overflow=1. Then pop with code_ready=1 -> data returned in order 8'h01..8'h08, then code_valid=0.
- 5 ps2_clk edges, then idle for more than TIMEOUT_CYC, then a full frame 8'hF0 -> exactly one entry, 8'hF0; no frame_err.
- FIFO full with code_ready=1 held while a new frame 8'h2A completes -> no overflow, count stays 8, 8'h2A later emerges last.
- rst_n pulsed low after 4 bits of a frame, then frame 8'h45 -> all outputs reset during rst_n low; afterwards code_data=8'h45 and no error flags.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 keyboard constants and types.
//   PS2_FRAME_BITS - ps2_clk falling edges per frame (start, 8 data, parity, stop)
//   PS2_BREAK      - key-release prefix code
//   PS2_EXT        - extended-key prefix code
//   scan_code_t    - one received scan code byte
package ps2_pkg;
    localparam int PS2_FRAME_BITS = 11;

    typedef logic [7:0] scan_code_t;

    localparam scan_code_t PS2_BREAK = 8'hF0;
    localparam scan_code_t PS2_EXT   = 8'hE0;
endpackage

// File: rtl/ps2_kbd_rx_if.sv
// ps2_kbd_rx_if: valid/ready scan-code stream between the receiver and its consumer.
//   code_valid - at least one code is available
//   code_data  - oldest available code (fall-through)
//   code_ready - consumer takes code_data this cycle
// master = producer (receiver), slave = consumer.
interface ps2_kbd_rx_if;
    logic                 code_valid;
    logic                 code_ready;
    ps2_pkg::scan_code_t  code_data;

    modport master (output code_valid, output code_data, input code_ready);
    modport slave  (input code_valid, input code_data, output code_ready);
endinterface

// File: rtl/ps2_fifo.sv
// ps2_fifo: synchronous first-word fall-through FIFO of scan codes.
//   clk, rst_n - clock, async active-low reset
//   push       - write push_data (accepted when not full, or when full and popping)
//   pop        - discard the head entry (ignored when empty)
//   full/empty - occupancy status
//   rd_data    - head entry, valid whenever empty=0
module ps2_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  scan_code_t push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output scan_code_t rd_data
);
    localparam int AW = $clog2(DEPTH);

    scan_code_t     mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    cnt;
    logic           do_wr, do_rd;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign rd_data = mem[rd_ptr];
    assign do_rd   = pop && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_wr   = push && (!full || do_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            // Cleared so rd_data is never X, even while empty.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;  // DEPTH is a power of two: natural wrap
            end
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard frame receiver with scan-code FIFO and sticky error flags.
//   clk, rst_n        - system clock, async active-low reset
//   ps2_clk, ps2_data - raw pad inputs, asynchronous to clk
//   code_if (master)  - code_valid / code_data / code_ready scan-code stream
//   frame_err         - sticky: bad start, stop or parity seen
//   overflow          - sticky: valid frame dropped because the FIFO was full
//   clr_err           - synchronous clear of both sticky flags (a same-cycle event wins)
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 10000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    input  logic             clr_err,
    output logic             frame_err,
    output logic             overflow,
    ps2_kbd_rx_if.master     code_if
);
    localparam int         TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 1);

    logic [1:0]    clk_s, dat_s;
    logic          clk_prev;
    logic          fall;
    logic [3:0]    bitcnt;
    logic [9:0]    shreg;     // [0]=start, [8:1]=d0..d7, [9]=parity
    logic [TW-1:0] tcnt;
    logic          frame_end, frame_ok;
    logic          full, empty, pop;
    logic          push, ovf_evt, err_evt;

    // Synchronizers idle high so reset never fabricates a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s    <= 2'b11;
            dat_s    <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_s    <= {clk_s[0], ps2_clk};
            dat_s    <= {dat_s[0], ps2_data};
            clk_prev <= clk_s[1];
        end
    end

    assign fall = clk_prev && !clk_s[1];

    // Frame end is judged on the stop-bit edge itself: stop comes straight from the
    // synchronizer, so the push lands one clk after the edge pulse.
    assign frame_end = fall && (bitcnt == LAST_BIT);
    assign frame_ok  = !shreg[0] && dat_s[1] && (^shreg[9:1]);
    assign pop       = !empty && code_if.code_ready;
    assign push      = frame_end && frame_ok && (!full || pop);
    assign ovf_evt   = frame_end && frame_ok && full && !pop;
    assign err_evt   = frame_end && !frame_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitcnt <= '0;
            shreg  <= '0;
            tcnt   <= '0;
        end else if (fall) begin
            tcnt <= '0;
            if (bitcnt == LAST_BIT) begin
                bitcnt <= '0;
            end else begin
                shreg  <= {dat_s[1], shreg[9:1]};
                bitcnt <= bitcnt + 1'b1;
            end
        end else if (bitcnt != '0) begin
            // Stalled partial frame: silently abandon it.
            if (tcnt == TW'(TIMEOUT_CYC)) begin
                bitcnt <= '0;
                tcnt   <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end else begin
            tcnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (err_evt)      frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
            if (ovf_evt)      overflow  <= 1'b1;
            else if (clr_err) overflow  <= 1'b0;
        end
    end

    ps2_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (shreg[8:1]),
        .pop       (code_if.code_ready),
        .full      (full),
        .empty     (empty),
        .rd_data   (code_if.code_data)
    );

    assign code_if.code_valid = !empty;
endmodule
